cv32e40p_apu_arbiter: RTL and testbench

// - Shares one APU/FPU instance between NB_CORES cv32e40p cores in a PULP cluster.
// - Round-robin arbitration of the per-core APU request channels onto the single shared APU port.
// - Records the requester ID of every accepted operation in an in-order ID FIFO.
// - Routes each response (result and flags) back to the core that issued it.

---
 rtl/cv32e40p_apu_core_pkg.sv | 16 +
 rtl/cv32e40p_apu_id_fifo.sv | 54 +++++
 rtl/cv32e40p_apu_arbiter.sv | 120 ++++++++++++
 tb/tb_cv32e40p_apu_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_apu_core_pkg.sv
// Shared APU widths for the cv32e40p cluster, plus the request payload record
// the arbiter multiplexes from the selected core onto the shared APU port.
package cv32e40p_apu_core_pkg;

  localparam int APU_NARGS_CPU    = 3;
  localparam int APU_WOP_CPU      = 6;
  localparam int APU_NDSFLAGS_CPU = 15;
  localparam int APU_NUSFLAGS_CPU = 5;

  typedef struct packed {
    logic [APU_NARGS_CPU*32-1:0]  operands;
    logic [APU_WOP_CPU-1:0]       op;
    logic [APU_NDSFLAGS_CPU-1:0]  flags;
  } apu_req_t;

endpackage

// File: rtl/cv32e40p_apu_id_fifo.sv
// In-order FIFO of requester IDs for in-flight APU operations.
// DEPTH must be a power of two so the pointers wrap on their own.
module cv32e40p_apu_id_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (r_count == (PW+1)'(DEPTH));
  assign empty_o = (r_count == '0);
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign data_o  = r_mem[r_rd_ptr];

  // NOTE: storage has no reset; entries are only read once the count says they are valid.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/cv32e40p_apu_arbiter.sv
// Round-robin sharing of one APU between NB_CORES cores; an ID FIFO remembers
// who issued each accepted op so in-order responses return to the right core.
module cv32e40p_apu_arbiter
  import cv32e40p_apu_core_pkg::*;
#(
  parameter int NB_CORES        = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int NARGS           = APU_NARGS_CPU,
  parameter int WOP             = APU_WOP_CPU,
  parameter int NDSFLAGS        = APU_NDSFLAGS_CPU,
  parameter int NUSFLAGS        = APU_NUSFLAGS_CPU
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NB_CORES-1:0]          core_req_i,
  output logic [NB_CORES-1:0]          core_gnt_o,
  input  logic [NB_CORES*NARGS*32-1:0] core_operands_i,
  input  logic [NB_CORES*WOP-1:0]      core_op_i,
  input  logic [NB_CORES*NDSFLAGS-1:0] core_flags_i,
  output logic [NB_CORES-1:0]          core_rvalid_o,
  output logic [31:0]                  core_result_o,
  output logic [NUSFLAGS-1:0]          core_flags_o,
  output logic                         apu_req_o,
  input  logic                         apu_gnt_i,
  output logic [NARGS*32-1:0]          apu_operands_o,
  output logic [WOP-1:0]               apu_op_o,
  output logic [NDSFLAGS-1:0]          apu_flags_o,
  input  logic                         apu_rvalid_i,
  input  logic [31:0]                  apu_result_i,
  input  logic [NUSFLAGS-1:0]          apu_flags_i,
  output logic                         protocol_err_o
);

  localparam int IDW = $clog2(NB_CORES);

  logic [IDW-1:0] r_rr_ptr;
  logic           r_err;
  logic [IDW-1:0] w_sel;
  logic           w_found;
  logic           w_any_req;
  logic           w_accept;
  logic           w_pop;
  logic           w_full;
  logic           w_empty;
  logic [IDW-1:0] w_head;
  apu_req_t       w_payload;

  // NOTE: every combinational output gets a default first, so no path infers a latch.
  always_comb begin
    int idx;
    w_sel   = '0;
    w_found = 1'b0;
    idx     = 0;
    for (int i = 0; i < NB_CORES; i++) begin
      idx = int'(r_rr_ptr) + i;
      if (idx >= NB_CORES) idx = idx - NB_CORES;
      if (!w_found && core_req_i[idx]) begin
        w_found = 1'b1;
        w_sel   = IDW'(idx);
      end
    end
  end

  assign w_any_req = |core_req_i;
  // Gating with rst_ni keeps the handshakes quiet while reset is asserted.
  assign apu_req_o = rst_ni && w_any_req && !w_full;
  assign w_accept  = apu_req_o && apu_gnt_i;
  assign w_pop     = rst_ni && apu_rvalid_i && !w_empty;

  always_comb begin
    w_payload = '0;
    if (w_any_req) begin
      w_payload.operands = core_operands_i[int'(w_sel)*NARGS*32 +: NARGS*32];
      w_payload.op       = core_op_i[int'(w_sel)*WOP +: WOP];
      w_payload.flags    = core_flags_i[int'(w_sel)*NDSFLAGS +: NDSFLAGS];
    end
  end

  assign apu_operands_o = w_payload.operands;
  assign apu_op_o       = w_payload.op;
  assign apu_flags_o    = w_payload.flags;

  always_comb begin
    core_gnt_o    = '0;
    core_rvalid_o = '0;
    if (w_accept) core_gnt_o[w_sel]     = 1'b1;
    if (w_pop)    core_rvalid_o[w_head] = 1'b1;
  end

  assign core_result_o  = apu_result_i;
  assign core_flags_o   = apu_flags_i;
  assign protocol_err_o = r_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr_ptr <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept)
        r_rr_ptr <= (w_sel == IDW'(NB_CORES-1)) ? '0 : w_sel + 1'b1;
      if (apu_rvalid_i && w_empty)
        r_err <= 1'b1;
    end
  end

  cv32e40p_apu_id_fifo #(
    .WIDTH (IDW),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_accept),
    .data_i  (w_sel),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

endmodule

// File: tb/tb_cv32e40p_apu_arbiter.sv
// Directed bench for the APU arbiter: a vector table for single-cycle behaviour
// plus hand-written sequences for reset, fairness and FIFO-full corners.
module tb_cv32e40p_apu_arbiter;

  logic         clk;
  logic         rst_ni;
  logic [3:0]   core_req_i;
  logic [3:0]   core_gnt_o;
  logic [383:0] core_operands_i;
  logic [23:0]  core_op_i;
  logic [59:0]  core_flags_i;
  logic [3:0]   core_rvalid_o;
  logic [31:0]  core_result_o;
  logic [4:0]   core_flags_o;
  logic         apu_req_o;
  logic         apu_gnt_i;
  logic [95:0]  apu_operands_o;
  logic [5:0]   apu_op_o;
  logic [14:0]  apu_flags_o;
  logic         apu_rvalid_i;
  logic [31:0]  apu_result_i;
  logic [4:0]   apu_flags_i;
  logic         protocol_err_o;

  int n_checks = 0;
  int n_fail   = 0;

  cv32e40p_apu_arbiter dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .core_req_i      (core_req_i),
    .core_gnt_o      (core_gnt_o),
    .core_operands_i (core_operands_i),
    .core_op_i       (core_op_i),
    .core_flags_i    (core_flags_i),
    .core_rvalid_o   (core_rvalid_o),
    .core_result_o   (core_result_o),
    .core_flags_o    (core_flags_o),
    .apu_req_o       (apu_req_o),
    .apu_gnt_i       (apu_gnt_i),
    .apu_operands_o  (apu_operands_o),
    .apu_op_o        (apu_op_o),
    .apu_flags_o     (apu_flags_o),
    .apu_rvalid_i    (apu_rvalid_i),
    .apu_result_i    (apu_result_i),
    .apu_flags_i     (apu_flags_i),
    .protocol_err_o  (protocol_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic        gnt;
    logic        rv;
    logic [31:0] res;
    logic [3:0]  exp_gnt;
    logic [3:0]  exp_rv;
    logic        exp_req;
    logic [5:0]  exp_op;
    logic        exp_err;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge and check outputs before the rising edge.
  task automatic step(input logic [3:0] req, input logic gnt, input logic rv,
                      input logic [31:0] res, input logic [3:0] eg, input logic [3:0] erv,
                      input logic ereq, input logic [5:0] eop, input logic eerr,
                      input string name);
    logic [31:0] exp_opnd;
    @(negedge clk);
    core_req_i   = req;
    apu_gnt_i    = gnt;
    apu_rvalid_i = rv;
    apu_result_i = res;
    apu_flags_i  = res[4:0];
    #2;
    exp_opnd = (eop == 6'd0) ? 32'h0 : 32'hA000_0000 + 32'((int'(eop) - 1) * 16);
    check({name, " gnt"},      {28'h0, core_gnt_o},    {28'h0, eg});
    check({name, " rvalid"},   {28'h0, core_rvalid_o}, {28'h0, erv});
    check({name, " apu_req"},  {31'h0, apu_req_o},     {31'h0, ereq});
    check({name, " op"},       {26'h0, apu_op_o},      {26'h0, eop});
    check({name, " operand0"}, apu_operands_o[31:0],   exp_opnd);
    check({name, " dsflags"},  {17'h0, apu_flags_o},   {26'h0, eop});
    check({name, " err"},      {31'h0, protocol_err_o}, {31'h0, eerr});
    check({name, " result"},   core_result_o,          res);
    check({name, " usflags"},  {27'h0, core_flags_o},  {27'h0, res[4:0]});
  endtask

  initial begin
    vecs[0]  = '{4'b0010, 1, 0, 32'h0,        4'b0010, 4'b0000, 1, 6'd2, 0};
    vecs[1]  = '{4'b0000, 0, 0, 32'h0,        4'b0000, 4'b0000, 0, 6'd0, 0};
    vecs[2]  = '{4'b0000, 0, 1, 32'hDEADBEEF, 4'b0000, 4'b0010, 0, 6'd0, 0};
    vecs[3]  = '{4'b1000, 1, 0, 32'h0,        4'b1000, 4'b0000, 1, 6'd4, 0};
    vecs[4]  = '{4'b0010, 1, 0, 32'h0,        4'b0010, 4'b0000, 1, 6'd2, 0};
    vecs[5]  = '{4'b0001, 1, 1, 32'h11,       4'b0001, 4'b1000, 1, 6'd1, 0};
    vecs[6]  = '{4'b0000, 0, 1, 32'h22,       4'b0000, 4'b0010, 0, 6'd0, 0};
    vecs[7]  = '{4'b0000, 0, 1, 32'h33,       4'b0000, 4'b0001, 0, 6'd0, 0};
    vecs[8]  = '{4'b0000, 0, 1, 32'h44,       4'b0000, 4'b0000, 0, 6'd0, 0};
    vecs[9]  = '{4'b0000, 0, 0, 32'h0,        4'b0000, 4'b0000, 0, 6'd0, 1};
    vecs[10] = '{4'b0100, 0, 0, 32'h0,        4'b0000, 4'b0000, 1, 6'd3, 1};
    vecs[11] = '{4'b0100, 1, 0, 32'h0,        4'b0100, 4'b0000, 1, 6'd3, 1};
    vecs[12] = '{4'b0000, 0, 1, 32'h55,       4'b0000, 4'b0100, 0, 6'd0, 1};
    vecs[13] = '{4'b0111, 1, 0, 32'h0,        4'b0001, 4'b0000, 1, 6'd1, 1};
    vecs[14] = '{4'b0111, 1, 0, 32'h0,        4'b0010, 4'b0000, 1, 6'd2, 1};
    vecs[15] = '{4'b0000, 0, 1, 32'h66,       4'b0000, 4'b0001, 0, 6'd0, 1};
    vecs[16] = '{4'b0000, 0, 1, 32'h77,       4'b0000, 4'b0010, 0, 6'd0, 1};

    for (int c = 0; c < 4; c++) begin
      core_op_i[c*6 +: 6]     = 6'(c + 1);
      core_flags_i[c*15 +: 15] = 15'(c + 1);
      for (int a = 0; a < 3; a++)
        core_operands_i[(c*3 + a)*32 +: 32] = 32'hA000_0000 + 32'(c*16 + a);
    end

    // Reset with every input active: handshakes must stay low.
    rst_ni       = 1'b0;
    core_req_i   = 4'b1111;
    apu_gnt_i    = 1'b1;
    apu_rvalid_i = 1'b1;
    apu_result_i = 32'h0;
    apu_flags_i  = 5'h0;
    #12;
    check("reset gnt",     {28'h0, core_gnt_o},     32'h0);
    check("reset rvalid",  {28'h0, core_rvalid_o},  32'h0);
    check("reset apu_req", {31'h0, apu_req_o},      32'h0);
    check("reset err",     {31'h0, protocol_err_o}, 32'h0);
    @(negedge clk);
    core_req_i   = 4'b0000;
    apu_gnt_i    = 1'b0;
    apu_rvalid_i = 1'b0;
    rst_ni       = 1'b1;

    for (int i = 0; i < 17; i++)
      step(vecs[i].req, vecs[i].gnt, vecs[i].rv, vecs[i].res, vecs[i].exp_gnt,
           vecs[i].exp_rv, vecs[i].exp_req, vecs[i].exp_op, vecs[i].exp_err,
           $sformatf("vec%0d", i));

    // Two ops in flight, then reset mid-operation.
    step(4'b1000, 1, 0, 32'h0, 4'b1000, 4'b0000, 1, 6'd4, 1, "inflight0");
    step(4'b0100, 1, 0, 32'h0, 4'b0100, 4'b0000, 1, 6'd3, 1, "inflight1");
    @(negedge clk);
    rst_ni       = 1'b0;
    core_req_i   = 4'b1111;
    apu_gnt_i    = 1'b1;
    apu_rvalid_i = 1'b1;
    #2;
    check("midreset gnt",     {28'h0, core_gnt_o},     32'h0);
    check("midreset rvalid",  {28'h0, core_rvalid_o},  32'h0);
    check("midreset apu_req", {31'h0, apu_req_o},      32'h0);
    check("midreset err",     {31'h0, protocol_err_o}, 32'h0);
    @(negedge clk);
    core_req_i   = 4'b0000;
    apu_gnt_i    = 1'b0;
    apu_rvalid_i = 1'b0;
    rst_ni       = 1'b1;

    // All cores request every cycle: fair order from core 0, each response one cycle later.
    for (int k = 0; k < 8; k++)
      step(4'b1111, 1, (k > 0), 32'(k), 4'(1 << (k % 4)),
           (k > 0) ? 4'(1 << ((k - 1) % 4)) : 4'b0000, 1, 6'(k % 4 + 1), 0,
           $sformatf("rr%0d", k));

    // Fill the FIFO (one entry left over from the round-robin run).
    for (int k = 0; k < 3; k++)
      step(4'b1111, 1, 0, 32'h0, 4'(1 << k), 4'b0000, 1, 6'(k + 1), 0,
           $sformatf("fill%0d", k));
    step(4'b0100, 1, 0, 32'h0,  4'b0000, 4'b0000, 0, 6'd3, 0, "full_blocked");
    step(4'b0100, 1, 1, 32'hAA, 4'b0000, 4'b1000, 0, 6'd3, 0, "full_pop");
    step(4'b0100, 1, 0, 32'h0,  4'b0100, 4'b0000, 1, 6'd3, 0, "after_pop_gnt");
    step(4'b0000, 0, 1, 32'hB1, 4'b0000, 4'b0001, 0, 6'd0, 0, "drain0");
    step(4'b0000, 0, 1, 32'hB2, 4'b0000, 4'b0010, 0, 6'd0, 0, "drain1");
    step(4'b0000, 0, 1, 32'hB3, 4'b0000, 4'b0100, 0, 6'd0, 0, "drain2");
    step(4'b0000, 0, 1, 32'hB4, 4'b0000, 4'b0100, 0, 6'd0, 0, "drain3");
    step(4'b0000, 0, 1, 32'hC0, 4'b0000, 4'b0000, 0, 6'd0, 0, "empty_rv");
    step(4'b0000, 0, 0, 32'h0,  4'b0000, 4'b0000, 0, 6'd0, 1, "err_set");
    step(4'b0000, 0, 0, 32'h0,  4'b0000, 4'b0000, 0, 6'd0, 1, "err_held");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
